// File: rtl/trigger_capture.sv
// Sticky event capture for fabric triggers: accumulates per-channel events and
// overruns between host reads, then snapshots and clears them atomically on snap.
module trigger_capture #(
  parameter int N    = 16,
  parameter int EDGE = 0,
  parameter int CW   = 8
) (
  input  logic          clk1,
  input  logic          reset1,
  input  logic [N-1:0]  trig_in,
  input  logic [N-1:0]  mask,
  input  logic          snap,
  output logic [N-1:0]  snap_data,
  output logic [N-1:0]  snap_ovf,
  output logic [CW-1:0] snap_count,
  output logic          snap_valid,
  output logic          pending
);

  typedef enum logic {ACCUM, SNAP} state_t;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t        state;
  logic [N-1:0]  trig_d;
  logic [N-1:0]  sticky;
  logic [N-1:0]  ovf_live;
  logic [CW-1:0] cnt_live;
  logic [N-1:0]  raw;
  logic [N-1:0]  ev;
  logic          any_ev;

  // Level mode counts every high cycle; edge mode only counts 0->1 transitions.
  assign raw    = (EDGE != 0) ? (trig_in & ~trig_d) : trig_in;
  assign ev     = mask & raw;
  assign any_ev = |ev;

  // Window FSM plus the live accumulators and snapshot registers. A snap
  // latches the pre-edge window and seeds the new window with this cycle's
  // events, so a coincident event is counted exactly once.
  always_ff @(posedge clk1) begin
    if (reset1) begin
      state      <= ACCUM;
      trig_d     <= trig_in;
      sticky     <= '0;
      ovf_live   <= '0;
      cnt_live   <= '0;
      snap_data  <= '0;
      snap_ovf   <= '0;
      snap_count <= '0;
    end else begin
      trig_d <= trig_in;
      if (snap) begin
        state      <= SNAP;
        snap_data  <= sticky;
        snap_ovf   <= ovf_live;
        snap_count <= cnt_live;
        sticky     <= ev;
        ovf_live   <= '0;
        cnt_live   <= any_ev ? CNT_ONE : '0;
      end else begin
        state    <= ACCUM;
        sticky   <= sticky | ev;
        ovf_live <= ovf_live | (ev & sticky);
        if (any_ev && (cnt_live != CNT_MAX)) begin
          cnt_live <= cnt_live + CNT_ONE;
        end
      end
    end
  end

  assign snap_valid = (state == SNAP);
  assign pending    = |sticky;

endmodule

// File: doc/trigger_capture.md
Name: trigger_capture

Overview:
- Receiving end of fabric event triggers.
- Collects single-cycle event pulses, such as counter-equality flags, into a sticky register on one clock, and flags per-bit overruns.
- On a host read strobe (decoded from an okTriggerIn bit), atomically snapshots and clears the accumulated events so they can be presented on okWireOut endpoints.
- Sits between event-producing logic and the host endpoint set, so no event is lost between host polls.

Parameters:
N, 16, number of trigger channels (1..16).
EDGE, 0, 0 = each cycle trig_in[i] is high counts as an event; 1 = only a rising edge of trig_in[i] counts.
CW, 8, width of the saturating event-cycle counter.

Ports:
clk1  input  1  block clock; all logic on posedge.
reset1  input  1  synchronous, active-high reset.
trig_in  input  N  event inputs, synchronous to clk1.
mask  input  N  1 = channel enabled; 0 = channel ignored (no capture, no overflow).
snap  input  1  single-cycle read strobe: snapshot and clear.
snap_data  output  N  events captured in the last completed window.
snap_ovf  output  N  channels that saw 2 or more events in the last window.
snap_count  output  CW  number of cycles with at least one event in the last window, saturating.
snap_valid  output  1  one-cycle pulse marking new snapshot outputs.
pending  output  1  1 when the live sticky register is non-zero.

Behaviour:
- Event vector: ev = mask & (EDGE ? (trig_in & ~trig_d) : trig_in). trig_d is trig_in registered each cycle.
- Reset (reset1 high at posedge):
  - sticky, ovf_live, cnt_live, snap_data, snap_ovf, snap_count, snap_valid all clear to 0.
  - trig_d loads trig_in, so a level held through reset creates no edge event.
  - pending = 0 the cycle after reset.
- Normal cycle, snap = 0:
  - sticky <= sticky | ev.
  - ovf_live <= ovf_live | (ev & sticky).
  - cnt_live <= cnt_live + 1 when ev != 0, saturating at 2^CW-1 (no wrap).
- Snap cycle, snap = 1 at posedge:
  - snap_data <= sticky; snap_ovf <= ovf_live; snap_count <= cnt_live. These use values from before this cycle's ev.
  - Same edge: sticky <= ev, ovf_live <= 0, cnt_live <= (ev != 0) ? 1 : 0. An event coincident with snap belongs to the new window and is never lost or double-counted.
  - snap_valid = 1 during the cycle after the snap edge only (latency 1).
  - Snapshot outputs hold until the next snap or reset.
- Back-to-back snaps (snap high on consecutive cycles):
  - Each one snapshots the one-cycle window; snap_valid stays high continuously.
  - An empty window yields snap_data = 0, snap_count = 0.
- pending = |sticky (registered sticky, combinational OR); usable as a host poll flag.
- Overflow:
  - A channel's second and later events in one window set its ovf bit.
  - sticky stays 1 for that channel.
  - Two bits firing in the same cycle are not an overflow.
- Mask:
  - Deasserting a mask bit does not clear already-captured sticky or ovf state for that channel.
  - It only blocks new events.
- Reset asserted together with snap: reset wins; snap_valid stays 0.
- Control structure: two-state window FSM.
  - ACCUM: default.
  - SNAP: one cycle, drives snap_valid.
  - SNAP -> SNAP on a repeated snap; SNAP -> ACCUM otherwise.
  - Reset -> ACCUM.

Test Plan:
- Reset with trig_in = 16'h0003 held, EDGE = 1, mask = all 1s, release reset, snap after 5 cycles -> snap_data = 0, snap_count = 0, snap_valid pulses for exactly 1 cycle.
- EDGE = 0: pulse bit 0 on one cycle and bit 7 on another; then snap -> snap_data = 16'h0081, snap_ovf = 0, snap_count = 2, pending falls to 0 the cycle after snap.
- Pulse bit 1 three times in one window; then snap -> snap_ovf = 16'h0002, snap_data = 16'h0002, snap_count = 3. The next snap with no events gives all zeros.
- Pulse bit 4 in the same cycle as snap (bit 2 captured earlier) -> first snapshot = 16'h0004; second snap -> 16'h0010, snap_count = 1.
- CW = 8, hold trig_in[0] high for 300 cycles with EDGE = 0; then snap -> snap_count = 255 (saturated), snap_ovf[0] = 1.
- mask = 16'hFFFE, pulse bits 0 and 3; snap held high for 2 consecutive cycles -> first snap_data = 16'h0008, second = 0; snap_valid high for 2 cycles.
